// File: rtl/sram_fifo_ctrl_if.sv
// Handshake and SRAM-side bundle for sram_fifo_ctrl.
// The slave modport is the controller's view; the master modport is the producer/consumer/SRAM environment's view.
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [DATA_WIDTH-1:0] push_data_i;
  logic                  pop_valid_o;
  logic                  pop_ready_i;
  logic [DATA_WIDTH-1:0] pop_data_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_wdata_o;
  logic                  sram_we_o;
  logic [DATA_WIDTH-1:0] sram_rdata_i;
  logic                  empty_o;
  logic                  full_o;

  modport slave (
    input  push_valid_i, push_data_i, pop_ready_i, sram_rdata_i,
    output push_ready_o, pop_valid_o, pop_data_o, sram_addr_o, sram_wdata_o,
           sram_we_o, empty_o, full_o
  );

  modport master (
    output push_valid_i, push_data_i, pop_ready_i, sram_rdata_i,
    input  push_ready_o, pop_valid_o, pop_data_o, sram_addr_o, sram_wdata_o,
           sram_we_o, empty_o, full_o
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller owning a single-port SRAM (1-cycle read latency).
// Reads prefetch into a 2-entry output buffer; SRAM read/write contention is arbitrated round-robin.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input logic             clk,
  input logic             rst,
  sram_fifo_ctrl_if.slave bus
);

  typedef enum logic {WRITE_FIRST = 1'b0, READ_FIRST = 1'b1} rr_e;

  localparam int                    CNT_W     = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [DATA_WIDTH-1:0] ob_q [2];
  logic [DATA_WIDTH-1:0] ob_d [2];
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  rr_e                   rr_q, rr_d;

  logic       pop_valid, pop_fire, push_ready, push_fire;
  logic       not_full, rd_want, wr_want, rd_grant;
  logic [2:0] occ;

  // occ is the output buffer occupancy after this cycle's pop, including any read already in flight.
  always_comb begin
    pop_valid  = (ob_cnt_q != 2'd0);
    pop_fire   = pop_valid & bus.pop_ready_i;
    not_full   = (count_q < DEPTH_CNT);
    occ        = {1'b0, ob_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop_fire};
    rd_want    = (count_q != '0) & (occ <= 3'd1);
    wr_want    = bus.push_valid_i & not_full;
    push_ready = !rst & not_full & (!rd_want | (rr_q == WRITE_FIRST));
    push_fire  = bus.push_valid_i & push_ready;
    rd_grant   = rd_want & !(wr_want & (rr_q == WRITE_FIRST));
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rd_inflight_d = rd_grant;
    rr_d          = rr_q;
    ob_d          = ob_q;
    ob_cnt_d      = ob_cnt_q;

    if (push_fire) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_grant) begin
      rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_fire, rd_grant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (rd_want & wr_want) begin
      rr_d = (rr_q == WRITE_FIRST) ? READ_FIRST : WRITE_FIRST;
    end

    // Head removal happens before the returning read word is appended.
    if (pop_fire) begin
      ob_d[0]  = ob_q[1];
      ob_cnt_d = ob_cnt_q - 2'd1;
    end
    if (rd_inflight_q) begin
      if (ob_cnt_d == 2'd0) begin
        ob_d[0] = bus.sram_rdata_i;
      end else begin
        ob_d[1] = bus.sram_rdata_i;
      end
      ob_cnt_d = ob_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_inflight_q <= 1'b0;
      ob_q[0]       <= '0;
      ob_q[1]       <= '0;
      ob_cnt_q      <= 2'd0;
      rr_q          <= WRITE_FIRST;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_inflight_q <= rd_inflight_d;
      ob_q[0]       <= ob_d[0];
      ob_q[1]       <= ob_d[1];
      ob_cnt_q      <= ob_cnt_d;
      rr_q          <= rr_d;
    end
  end

  assign bus.push_ready_o = push_ready;
  assign bus.pop_valid_o  = pop_valid;
  assign bus.pop_data_o   = ob_q[0];
  assign bus.sram_we_o    = push_fire;
  assign bus.sram_addr_o  = push_fire ? wr_ptr_q : rd_ptr_q;
  assign bus.sram_wdata_o = bus.push_data_i;
  assign bus.empty_o      = (count_q == '0) & !rd_inflight_q & (ob_cnt_q == 2'd0);
  assign bus.full_o       = (count_q == DEPTH_CNT) & (ob_cnt_q == 2'd2);

endmodule
